data_cache_ctrl: RTL and testbench
==================================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001: Parameter DATA_WIDTH, default 32, CPU and memory data/address width.
REQ-002: Parameter SETS, default 256, number of direct-mapped lines; power of two; one 32-bit word per line.
REQ-003: clk  in  1  single clock; all state updates on rising edge.
REQ-004: rst_n  in  1  asynchronous active-low reset.
REQ-005: cpu_req  in  1  CPU access valid this cycle.
REQ-006: cpu_we  in  1  1 = store, 0 = load.
REQ-007: cpu_addr  in  32  byte address.
REQ-008: cpu_wdata  in  32  store data, LSB-aligned.
REQ-009: cpu_funct3  in  3  RV32I load/store type (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010: cpu_rdata  out  32  load result, extended per funct3.
REQ-011: stall  out  1  CPU must hold its request unchanged while high.
REQ-012: mem_fetch  out  1  read line from main memory.
REQ-013: mem_writeback  out  1  write victim line to main memory.
REQ-014: mem_addr  out  32  word address to main memory.
REQ-015: mem_wdata  out  32  victim data during writeback.
REQ-016: mem_rdata  in  32  main-memory read data, combinational from mem_addr while mem_fetch is high.

Function
REQ-017: Address split: offset = cpu_addr[1:0], index = cpu_addr[log2(SETS)+1:2], tag = remaining upper bits.
REQ-018: Per line: valid bit, dirty bit, tag, 32-bit data.
REQ-019: FSM states IDLE, WRITEBACK, FILL; reset state IDLE.
REQ-020: IDLE, cpu_req high, line valid and tag match (hit): stall = 0; load drives cpu_rdata combinationally the same cycle; store merges bytes into line at the clock edge and sets dirty.
REQ-021: IDLE, cpu_req high, miss, victim valid and dirty: stall = 1, go to WRITEBACK.
REQ-022: IDLE, cpu_req high, miss, victim invalid or clean: stall = 1, go to FILL.
REQ-023: WRITEBACK, exactly one cycle: mem_writeback = 1, mem_addr = {victim tag, index} as word address, mem_wdata = victim data; stall = 1; next FILL.
REQ-024: FILL, exactly one cycle: mem_fetch = 1, mem_addr = cpu_addr[31:2] zero-extended; line <= {valid = 1, dirty = 0, new tag, mem_rdata}; stall = 1; next IDLE.
REQ-025: After FILL the re-presented request hits in IDLE. Miss latency: 1 stall cycle clean, 2 stall cycles dirty.
REQ-026: mem_fetch and mem_writeback are never high together; both are 0 in IDLE.
REQ-027: Load extension: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign- or zero-extend to 32 bits; LW ignores addr[1:0].
REQ-028: Store merge: SB writes byte addr[1:0] from wdata[7:0]; SH writes half addr[1] from wdata[15:0]; SW writes the full word; other bytes are preserved.
REQ-029: cpu_req low in IDLE: no state change, stall = 0, cpu_rdata = 0.
REQ-030: cpu_req, cpu_addr or cpu_we changing while stall is high is a CPU protocol violation; the FSM completes its sequence using the values sampled at each edge.

Reset
REQ-031: rst_n low asynchronously clears all valid and dirty bits, forces IDLE, and drives stall, mem_fetch and mem_writeback to 0 and mem_addr, mem_wdata and cpu_rdata to 0.
REQ-032: Reset during WRITEBACK or FILL aborts the transfer; no line is updated and dirty data is discarded.
REQ-033: Tag and data arrays need no reset.

Structure
REQ-034: Shared package cache_pkg holds the state enum, the funct3 load/store constants, and the default SETS.
REQ-035: One sub-module, cache_byte_align, holds the combinational load extension and store byte merge.

Verification
REQ-036: Reset, then LW 0x0004_0000 with memory word 0x0001_0000 = 0xDEADBEEF -> stall for 1 cycle with mem_fetch = 1 and mem_addr = 0x0001_0000, next cycle hit returning 0xDEADBEEF.
REQ-037: SB 0x0004_0001 data 0xAA after that fill -> no stall, line becomes 0xDEADAAEF and dirty; LBU 0x0004_0001 -> 0x000000AA; LB -> 0xFFFFFFAA.
REQ-038: LW 0x0004_0400 (same index, new tag) after REQ-037 -> WRITEBACK with mem_addr 0x0001_0000 and mem_wdata 0xDEADAAEF, then FILL with mem_addr 0x0001_0100; 2 stall cycles.
REQ-039: LH 0x0004_0402 over memory 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-040: rst_n asserted during the WRITEBACK cycle -> outputs 0 immediately; a following LW to the old address misses with 1 stall cycle (line invalid, no writeback).

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the direct-mapped data cache
package cache_pkg;

    localparam int DEFAULT_SETS = 256;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } cache_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/cache_byte_align.sv
// rtl/cache_byte_align.sv - load sub-word extension and store byte merge on one cache word
module cache_byte_align
    import cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{offset, 3'b000} +: 8];
        sel_half = word[{offset[1], 4'b0000} +: 16];
    end

    always_comb begin
        load_data = word;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  load_data = {24'h0, sel_byte};
            F3_LHU:  load_data = {16'h0, sel_half};
            default: load_data = word;
        endcase
    end

    // Unsupported store encodings leave the line untouched.
    always_comb begin
        store_data = word;
        case (funct3)
            F3_SB:   store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_SH:   store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            F3_SW:   store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back data cache controller, one word per line
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = DEFAULT_SETS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_fetch,
    output logic                  mem_writeback,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

    cache_state_e          state;
    logic [SETS-1:0]       valid_q;
    logic [SETS-1:0]       dirty_q;
    logic [TAG_W-1:0]      tag_arr  [SETS];
    logic [DATA_WIDTH-1:0] data_arr [SETS];

    logic                  mem_fetch_q;
    logic                  mem_writeback_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [DATA_WIDTH-1:0] line_word;
    logic                  hit;
    logic                  in_idle;
    logic                  access_hit;
    logic                  access_miss;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;

    assign idx         = cpu_addr[IDX_W+1:2];
    assign tag         = cpu_addr[DATA_WIDTH-1:IDX_W+2];
    // The fill target is taken from the registered fetch address so tag and data stay paired.
    assign fill_idx    = mem_addr_q[IDX_W-1:0];
    assign fill_tag    = mem_addr_q[DATA_WIDTH-3:IDX_W];
    assign line_word   = data_arr[idx];
    assign hit         = valid_q[idx] && (tag_arr[idx] == tag);
    assign in_idle     = (state == ST_IDLE);
    assign access_hit  = in_idle && cpu_req && hit;
    assign access_miss = in_idle && cpu_req && !hit;

    cache_byte_align u_byte_align (
        .word       (line_word),
        .offset     (cpu_addr[1:0]),
        .funct3     (cpu_funct3),
        .wdata      (cpu_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Gated by rst_n so the outputs drop the moment reset is asserted.
    assign stall         = rst_n && (access_miss || !in_idle);
    assign cpu_rdata     = (rst_n && access_hit && !cpu_we) ? load_data : '0;
    assign mem_fetch     = mem_fetch_q;
    assign mem_writeback = mem_writeback_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_fetch_q     <= 1'b0;
            mem_writeback_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access_hit && cpu_we) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (access_miss) begin
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state           <= ST_WRITEBACK;
                            mem_writeback_q <= 1'b1;
                            mem_addr_q      <= {2'b00, tag_arr[idx], idx};
                            mem_wdata_q     <= data_arr[idx];
                        end else begin
                            state       <= ST_FILL;
                            mem_fetch_q <= 1'b1;
                            mem_addr_q  <= {2'b00, cpu_addr[DATA_WIDTH-1:2]};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    state           <= ST_FILL;
                    mem_writeback_q <= 1'b0;
                    mem_wdata_q     <= '0;
                    mem_fetch_q     <= 1'b1;
                    mem_addr_q      <= {2'b00, cpu_addr[DATA_WIDTH-1:2]};
                end
                ST_FILL: begin
                    state             <= ST_IDLE;
                    mem_fetch_q       <= 1'b0;
                    mem_addr_q        <= '0;
                    valid_q[fill_idx] <= 1'b1;
                    dirty_q[fill_idx] <= 1'b0;
                end
                default: begin
                    state           <= ST_IDLE;
                    mem_fetch_q     <= 1'b0;
                    mem_writeback_q <= 1'b0;
                    mem_addr_q      <= '0;
                    mem_wdata_q     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FILL) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem_rdata;
        end else if (access_hit && cpu_we) begin
            data_arr[idx] <= store_data;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb/tb_data_cache_ctrl.sv - self-checking bench for data_cache_ctrl against a flat-memory reference
module tb_data_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_fetch;
    logic        mem_writeback;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    data_cache_ctrl #(.DATA_WIDTH(32), .SETS(256)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_funct3    (cpu_funct3),
        .cpu_rdata     (cpu_rdata),
        .stall         (stall),
        .mem_fetch     (mem_fetch),
        .mem_writeback (mem_writeback),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory seen by the DUT, and the architectural memory the CPU should observe.
    logic [31:0] bk_mem  [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];

    bit          m_valid [256];
    bit          m_dirty [256];
    logic [21:0] m_tag   [256];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] bk_rd(logic [31:0] a);
        if (bk_mem.exists(a)) return bk_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return bk_rd(a);
    endfunction

    function automatic logic [31:0] ref_ext(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] w, logic [31:0] wd, logic [1:0] off, logic [2:0] f3);
        logic [31:0] mask;
        case (f3)
            3'b000: begin
                mask = 32'hFF << (8 * off);
                return (w & ~mask) | ((wd & 32'hFF) << (8 * off));
            end
            3'b001: begin
                mask = 32'hFFFF << (16 * off[1]);
                return (w & ~mask) | ((wd & 32'hFFFF) << (16 * off[1]));
            end
            3'b010:  return wd;
            default: return w;
        endcase
    endfunction

    assign mem_rdata = bk_rd(mem_addr);

    always @(posedge clk) begin
        if (mem_writeback) bk_mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One CPU access held until it completes; returns load data and the number of memory cycles.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, output logic [31:0] rd, output int nmem);
        logic [7:0]  idx;
        logic [21:0] tg;
        logic [31:0] wa;
        logic [31:0] va;
        idx = addr[9:2];
        tg  = addr[31:10];
        wa  = {2'b00, addr[31:2]};
        nmem = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_funct3 = f3;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            @(negedge clk);
            check("miss_detect_stall", 32'(stall), 32'd1);
            check("miss_detect_mem_idle", {30'd0, mem_fetch, mem_writeback}, 32'd0);
            @(posedge clk); #1;
            if (m_valid[idx] && m_dirty[idx]) begin
                va = {2'b00, m_tag[idx], idx};
                @(negedge clk);
                nmem++;
                check("wb_flags", {30'd0, mem_fetch, mem_writeback}, 32'd1);
                check("wb_stall", 32'(stall), 32'd1);
                check("wb_addr", mem_addr, va);
                check("wb_data", mem_wdata, ref_rd(va));
                @(posedge clk); #1;
            end
            @(negedge clk);
            nmem++;
            check("fill_flags", {30'd0, mem_fetch, mem_writeback}, 32'd2);
            check("fill_stall", 32'(stall), 32'd1);
            check("fill_addr", mem_addr, wa);
            @(posedge clk); #1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        @(negedge clk);
        check("hit_stall", 32'(stall), 32'd0);
        check("hit_mem_idle", {30'd0, mem_fetch, mem_writeback}, 32'd0);
        rd = cpu_rdata;
        if (we) check("store_rdata_zero", cpu_rdata, 32'd0);
        else    check("load_data", cpu_rdata, ref_ext(ref_rd(wa), addr[1:0], f3));
        @(posedge clk); #1;
        if (we) begin
            ref_mem[wa]  = ref_merge(ref_rd(wa), wd, addr[1:0], f3);
            m_dirty[idx] = 1'b1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_flags"}, {30'd0, mem_fetch, mem_writeback}, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
        check({tag, "_rdata"}, cpu_rdata, 32'd0);
    endtask

    // Aborted writebacks lose dirty data, so architectural memory falls back to the backing copy.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            if (m_valid[i] && m_dirty[i]) ref_mem.delete({2'b00, m_tag[i], 8'(i)});
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    logic [31:0] rd;
    int          nmem;
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0004_0000; cpu_wdata = '0; cpu_funct3 = 3'b010;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        bk_mem[32'h0001_0000] = 32'hDEAD_BEEF;
        bk_mem[32'h0001_0100] = 32'h8001_1234;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        cpu_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle_noreq");
        @(posedge clk); #1;

        do_access(1'b0, 32'h0004_0000, 32'h0, 3'b010, rd, nmem);
        check("first_lw_data", rd, 32'hDEAD_BEEF);
        check("first_lw_memcycles", 32'(nmem), 32'd1);
        do_access(1'b1, 32'h0004_0001, 32'hAA, 3'b000, rd, nmem);
        check("sb_hit_memcycles", 32'(nmem), 32'd0);
        do_access(1'b0, 32'h0004_0000, 32'h0, 3'b010, rd, nmem);
        check("sb_merged_word", rd, 32'hDEAD_AAEF);
        do_access(1'b0, 32'h0004_0001, 32'h0, 3'b100, rd, nmem);
        check("lbu_byte", rd, 32'h0000_00AA);
        do_access(1'b0, 32'h0004_0001, 32'h0, 3'b000, rd, nmem);
        check("lb_byte", rd, 32'hFFFF_FFAA);
        do_access(1'b0, 32'h0004_0400, 32'h0, 3'b010, rd, nmem);
        check("dirty_miss_memcycles", 32'(nmem), 32'd2);
        check("victim_in_memory", bk_rd(32'h0001_0000), 32'hDEAD_AAEF);
        do_access(1'b0, 32'h0004_0402, 32'h0, 3'b001, rd, nmem);
        check("lh_half", rd, 32'hFFFF_8001);
        do_access(1'b0, 32'h0004_0402, 32'h0, 3'b101, rd, nmem);
        check("lhu_half", rd, 32'h0000_8001);

        do_access(1'b1, 32'h0004_0400, 32'h1234_5678, 3'b010, rd, nmem);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0004_0000; cpu_funct3 = 3'b010;
        @(negedge clk);
        check("abort_detect_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_in_wb", 32'(mem_writeback), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("abort_reset");
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        do_access(1'b0, 32'h0004_0400, 32'h0, 3'b010, rd, nmem);
        check("after_abort_memcycles", 32'(nmem), 32'd1);
        check("after_abort_data", rd, 32'h8001_1234);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            bit          w;
            a = {22'h100 + 22'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            w = 1'($urandom_range(0, 1));
            if (w) do_access(1'b1, a, $urandom, st_f3[$urandom_range(0, 2)], rd, nmem);
            else   do_access(1'b0, a, 32'h0, ld_f3[$urandom_range(0, 4)], rd, nmem);
            if ($urandom_range(0, 7) == 0) begin
                cpu_addr = a;
                @(negedge clk);
                check("rand_idle_stall", 32'(stall), 32'd0);
                check("rand_idle_rdata", cpu_rdata, 32'd0);
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
